// File: rtl/zx_kbd_pkg.sv
// Shared types and constants for the ZX Spectrum keyboard matrix scanner.
// Key index is row*5+col; KEY_CODE maps it to the PS/2 set-2 scancode.
package zx_kbd_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 5;
    localparam int NKEYS = 40;

    typedef struct packed {
        logic       pressed;
        logic [5:0] idx;
    } kbd_event_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } emit_state_e;

    localparam logic [7:0] KEY_CODE [NKEYS] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h14, 8'h3A, 8'h31, 8'h32
    };

    function automatic logic [10:0] ps2_word(input logic toggle, input kbd_event_t ev);
        return {toggle, ev.pressed, 1'b0, KEY_CODE[ev.idx]};
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Circular event queue; a push into a full queue is accepted when a pop
// happens in the same cycle, so a drain never stalls the scanner needlessly.
module kbd_event_fifo
    import zx_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  kbd_event_t wr_data,
    input  logic       pop,
    output kbd_event_t rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    kbd_event_t    mem_q [FIFO_DEPTH];
    kbd_event_t    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/zx_matrix_scanner.sv
// Scans an 8x5 Spectrum key matrix, debounces each key and emits paced
// make/break events on the 11-bit ps2_key bus.
module zx_matrix_scanner
    import zx_kbd_pkg::*;
#(
    parameter int SCAN_DIV   = 3500,
    parameter int DEBOUNCE   = 3,
    parameter int MIN_GAP    = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    output logic [7:0]  row_n,
    input  logic [4:0]  col_n,
    output logic [10:0] ps2_key,
    output logic [39:0] key_state
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam int RW = $clog2(ROWS);

    logic [4:0]       col_meta_q, col_sync_q, col_lat_q, col_lat_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [RW-1:0]    row_q, row_d;
    logic [7:0]       row_n_q, row_n_d;
    logic [NKEYS-1:0] key_state_q, key_state_d;
    logic [2:0]       cnt_q [NKEYS];
    logic [2:0]       cnt_d [NKEYS];
    emit_state_e      state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [10:0]      ps2_q, ps2_d;

    logic             eval_en_s, pressed_s, push_s, pop_s, fifo_ready_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [2:0]       eval_col_s;
    logic [5:0]       key_idx_s;
    kbd_event_t       push_ev_s, pop_ev_s;

    assign row_n     = row_n_q;
    assign ps2_key   = ps2_q;
    assign key_state = key_state_q;

    // The five cycles after the column latch evaluate columns 0..4 in turn
    assign eval_en_s    = (dwell_q >= DW'(SCAN_DIV - 5));
    assign eval_col_s   = 3'(dwell_q - DW'(SCAN_DIV - 5));
    assign key_idx_s    = 6'(row_q) * 6'(COLS) + 6'(eval_col_s);
    assign pressed_s    = ~col_lat_q[eval_col_s];
    assign fifo_ready_s = ~fifo_full_s | pop_s;

    // Row dwell timing, column latch and row advance
    always_comb begin
        dwell_d   = dwell_q + DW'(1);
        row_d     = row_q;
        row_n_d   = row_n_q;
        col_lat_d = col_lat_q;
        if (dwell_q == DW'(SCAN_DIV - 6)) begin
            col_lat_d = col_sync_q;
        end else begin
            col_lat_d = col_lat_q;
        end
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
            dwell_d = '0;
            row_d   = row_q + RW'(1);
            row_n_d = {row_n_q[6:0], row_n_q[7]};
        end else begin
            row_d = row_q;
        end
    end

    // Per-key debounce; a change blocked by a full queue keeps its count and retries next scan
    always_comb begin
        cnt_d             = cnt_q;
        key_state_d       = key_state_q;
        push_s            = 1'b0;
        push_ev_s.pressed = pressed_s;
        push_ev_s.idx     = key_idx_s;
        if (eval_en_s) begin
            if (pressed_s == key_state_q[key_idx_s]) begin
                cnt_d[key_idx_s] = '0;
            end else if (cnt_q[key_idx_s] < 3'(DEBOUNCE - 1)) begin
                cnt_d[key_idx_s] = cnt_q[key_idx_s] + 3'd1;
            end else if (fifo_ready_s) begin
                push_s                 = 1'b1;
                key_state_d[key_idx_s] = pressed_s;
                cnt_d[key_idx_s]       = '0;
            end else begin
                cnt_d[key_idx_s] = cnt_q[key_idx_s];
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Emitter: one-cycle pop/update, then a MIN_GAP cooldown
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        ps2_d   = ps2_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                pop_s   = 1'b1;
                ps2_d   = ps2_word(~ps2_q[10], pop_ev_s);
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GW'(MIN_GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; columns pass through a 2-FF synchroniser first
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            col_meta_q  <= 5'h1F;
            col_sync_q  <= 5'h1F;
            col_lat_q   <= 5'h1F;
            dwell_q     <= '0;
            row_q       <= '0;
            row_n_q     <= 8'hFE;
            key_state_q <= '0;
            cnt_q       <= '{default: '0};
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            ps2_q       <= 11'h000;
        end else begin
            col_meta_q  <= col_n;
            col_sync_q  <= col_meta_q;
            col_lat_q   <= col_lat_d;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            row_n_q     <= row_n_d;
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            gap_q       <= gap_d;
            ps2_q       <= ps2_d;
        end
    end

    kbd_event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .push   (push_s),
        .wr_data(push_ev_s),
        .pop    (pop_s),
        .rd_data(pop_ev_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

endmodule
